// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: state encoding,
// operand width, default watchdog limit and the requester-ID width helper.
package mul_arb_pkg;

  localparam int MUL_W       = 64;
  localparam int DEF_TIMEOUT = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the candidate closest to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sequencer sharing one Booth multiplier among N_REQ requesters,
// with mandatory op_clear after each operation and a BUSY watchdog.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int W       = MUL_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IW      = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ack,
  output logic               rsp_valid,
  output logic [IW-1:0]      rsp_id,
  output logic [2*W-1:0]     rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               mul_op_start,
  output logic               mul_op_clear,
  output logic [W-1:0]       mul_multiplier,
  output logic [W-1:0]       mul_multiplicand,
  input  logic               mul_op_done,
  input  logic [2*W-1:0]     mul_result
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  arb_state_e state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [CW-1:0]    wd_q, wd_d;
  logic [N_REQ-1:0] ack_d;
  logic             start_d, clear_d, rsp_valid_d, rsp_err_d, busy_d;
  logic [IW-1:0]    rsp_id_d;
  logic [2*W-1:0]   rsp_result_d;
  logic [W-1:0]     a_d, b_d, a_sel, b_sel;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  rr_pick #(.N(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    ack_d        = '0;
    start_d      = 1'b0;
    clear_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = rsp_err;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    a_d          = mul_multiplier;
    b_d          = mul_multiplicand;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d         = ST_BUSY;
          grant_d         = pick_idx;
          a_d             = a_sel;
          b_d             = b_sel;
          ack_d[pick_idx] = 1'b1;
          start_d         = 1'b1;
          wd_d            = '0;
        end
      end
      ST_BUSY: begin
        wd_d = wd_q + 1'b1;
        // Done is checked first so a result on the last watchdog cycle is kept.
        if (mul_op_done) begin
          rsp_result_d = mul_result;
          rsp_id_d     = grant_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          clear_d      = 1'b1;
          state_d      = ST_CLEAR;
        end else if (wd_q == WD_LAST) begin
          rsp_result_d = '0;
          rsp_id_d     = grant_q;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          clear_d      = 1'b1;
          state_d      = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      grant_q          <= '0;
      wd_q             <= '0;
      req_ack          <= '0;
      mul_op_start     <= 1'b0;
      mul_op_clear     <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_id           <= '0;
      rsp_result       <= '0;
      busy             <= 1'b0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_q          <= grant_d;
      wd_q             <= wd_d;
      req_ack          <= ack_d;
      mul_op_start     <= start_d;
      mul_op_clear     <= clear_d;
      rsp_valid        <= rsp_valid_d;
      rsp_err          <= rsp_err_d;
      rsp_id           <= rsp_id_d;
      rsp_result       <= rsp_result_d;
      busy             <= busy_d;
      mul_multiplier   <= a_d;
      mul_multiplicand <= b_d;
    end
  end

endmodule
